// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {
    MS_IDLE  = 2'b00,
    MS_PEND  = 2'b01,
    MS_VALID = 2'b10
  } mem_status_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
  localparam int unsigned INST_BYTES = 4;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small flushable FIFO of fetched {pc, inst} entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   push_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  // Flush wins over a same-cycle push; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    do_push = push & ~full & ~flush;
    do_pop  = pop & ~empty & ~flush;
    mem_d   = mem_q;
    if (do_push) mem_d[tail_q] = push_data;
    head_d  = flush ? '0 : head_q + AW'(do_pop);
    tail_d  = flush ? '0 : tail_q + AW'(do_push);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign head  = mem_q[head_q];
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, drives instruction memory and hands {pc, inst} to decode
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_stall,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_status,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0] pc_q, pc_d;
  logic beat, push, pop, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: pc_q, inst: mem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
  // A redirect discards any same-cycle beat and masks the handshake
  always_comb begin
    beat = mem_status == MS_VALID;
    push = beat & ~redirect_valid & ~full;
    pop  = out_valid & out_ready;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'(INST_BYTES) : pc_q;
  end
  always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
  assign mem_addr  = pc_q;
  assign mem_stall = rst | redirect_valid | (count == CW'(DEPTH));
  assign out_valid = ~empty & ~redirect_valid;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  // The stall holds memory idle while full, so a data beat can never meet a full queue
  always_ff @(posedge clk) if (!rst) assert (!(beat && full && !redirect_valid));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed checks of inst_fetch against a queue-based model
module tb_inst_fetch;
  import fetch_pkg::*;
  localparam logic [31:0] RPC = 32'hBFC0_0000;
  localparam int DEPTH = 2;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] mem_addr, mem_rdata, redirect_pc = 0, out_pc, out_inst;
  logic [1:0] mem_status;
  logic mem_stall, redirect_valid = 0, out_valid, out_ready = 0;
  logic [31:0] mem_addr2, out_pc2, out_inst2;
  logic [31:0] rdata2 = 32'h1234_5678;
  logic [1:0] st2 = 2'b00;
  logic mem_stall2, out_valid2;
  logic [1:0] ms = 2'b00;
  int cnt = 0;
  logic [31:0] rd = 0;
  logic ovr = 0;
  bit lat_rand = 0;
  int checks = 0, errors = 0;
  fetch_entry_t mq[$];
  logic [31:0] mpc = RPC;
  int first;
  int vis[$];
  logic [31:0] pcs[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .mem_status(mem_status),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_stall(mem_stall2),
    .mem_rdata(rdata2), .mem_status(st2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2), .out_inst(out_inst2)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: idle -> pending (latency) -> data beat -> idle; stall aborts to idle
  always @(posedge clk) begin
    if (mem_stall) ms <= 2'b00;
    else if (ms == 2'b00) begin
      ms  <= 2'b01;
      cnt <= lat_rand ? int'($urandom_range(0, 2)) : 1;
    end else if (ms == 2'b01) begin
      if (cnt == 0) begin
        ms <= 2'b10;
        rd <= word_of(mem_addr);
      end else cnt <= cnt - 1;
    end else ms <= 2'b00;
  end
  assign mem_status = ovr ? 2'b10 : ms;
  assign mem_rdata  = rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc, input logic ov);
    logic was_full;
    @(negedge clk);
    rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; ovr = ov;
    #1;
    if (r) chk("stall_in_rst", {31'b0, mem_stall}, 1);
    else begin
      chk("mem_addr", mem_addr, mpc);
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, rv || mq.size() == DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0 && !rv});
      if (mq.size() > 0 && !rv) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", out_inst, mq[0].inst);
      end
    end
    was_full = mq.size() == DEPTH;
    if (r) begin
      mq.delete();
      mpc = RPC;
    end else if (rv) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (mem_status == 2'b10 && !was_full) begin
        mq.push_back('{pc: mpc, inst: word_of(mpc)});
        mpc = mpc + 4;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_mem_addr", mem_addr, RPC);
    // Reset release with latency 1: beats after e4, e8, e12
    first = 0;
    for (int i = 1; i <= 13; i++) begin
      step(0, 1, 0, 0, 0);
      @(posedge clk); #1;
      if (out_valid) begin
        if (first == 0) first = i;
        vis.push_back(i);
        pcs.push_back(out_pc);
      end
    end
    chk("first_valid_edge", first, 4);
    chk("beat_count", vis.size(), 3);
    if (vis.size() >= 3) begin
      chk("beat1_edge", vis[1], 8);
      chk("beat2_edge", vis[2], 12);
      chk("pc0", pcs[0], 32'hBFC0_0000);
      chk("pc1", pcs[1], 32'hBFC0_0004);
      chk("pc2", pcs[2], 32'hBFC0_0008);
    end
    // Decode stalls for 20 cycles: queue fills and memory is held idle
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    chk("full_stall", {31'b0, mem_stall}, 1);
    chk("full_mem_idle", {30'b0, mem_status}, 0);
    chk("full_valid", {31'b0, out_valid}, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    // Redirect while memory is pending
    for (int k = 0; k < 20 && mem_status != 2'b01; k++) step(0, 1, 0, 0, 0);
    chk("found_pending", {30'b0, mem_status}, 1);
    step(0, 1, 1, 32'h8000_0103, 0);
    chk("redirect_masks_valid", {31'b0, out_valid}, 0);
    for (int k = 0; k < 20 && !out_valid; k++) step(0, 1, 0, 0, 0);
    chk("redirect_target_pc", out_pc, 32'h8000_0100);
    // Redirect coincident with a data beat on a full queue
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
    chk("pre_flush_full", {31'b0, mem_stall}, 1);
    step(0, 0, 1, 32'h0000_2000, 1);
    step(0, 1, 0, 0, 0);
    chk("flush_pc_target", mem_addr, 32'h0000_2000);
    chk("flush_empty", {31'b0, out_valid}, 0);
    // Random traffic with variable memory latency
    lat_rand = 1;
    for (int i = 0; i < 600; i++)
      step(0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom, 0);
    // Reset during a data beat with a valid head
    lat_rand = 0;
    step(0, 0, 1, 32'h0000_4000, 0);
    for (int k = 0; k < 40 && !(mem_status == 2'b10 && out_valid); k++) step(0, 0, 0, 0, 0);
    chk("found_beat_valid", {31'b0, mem_status == 2'b10 && out_valid}, 1);
    step(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_inst", out_inst, 0);
    chk("midrst_addr", mem_addr, RPC);
    chk("midrst_stall", {31'b0, mem_stall}, 1);
    // PC wrap from 0xFFFFFFFC
    @(negedge clk);
    rst = 0;
    st2 = 2'b10;
    #1;
    chk("wrap_addr0", mem_addr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    st2 = 2'b00;
    chk("wrap_addr1", mem_addr2, 32'h0000_0000);
    chk("wrap_valid", {31'b0, out_valid2}, 1);
    chk("wrap_out_pc", out_pc2, 32'hFFFF_FFFC);
    chk("wrap_out_inst", out_inst2, 32'h1234_5678);
    chk("wrap_stall", {31'b0, mem_stall2}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage. Owns the program counter, drives the instruction memory's address and stall inputs, and captures returned words into a small flushable queue. It presents `{pc, inst}` pairs to decode over a valid/ready handshake. It sits between the branch/redirect logic in execute and the instruction memory (upstream), and decode (downstream).

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC loaded on reset
- `DEPTH`, 2, instruction queue entries (≥2, power of 2)
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `mem_addr`  out  32  fetch address to instruction memory; equals current PC
- `mem_stall`  out  1  stall/abort to instruction memory
- `mem_rdata`  in  32  instruction word from memory
- `mem_status`  in  2  00 idle, 01 pending, 10 data valid (one-cycle beat), 11 unused
- `redirect_valid`  in  1  branch/jump/exception redirect
- `redirect_pc`  in  32  redirect target
- `out_valid`  out  1  queue head valid to decode
- `out_ready`  in  1  decode accepts head
- `out_pc`  out  32  PC of head instruction
- `out_inst`  out  32  head instruction word

## Operation
- State: `pc` register and queue (`count` 0..DEPTH, head/tail pointers).
- Memory protocol:
  - Memory self-sequences 00→01→(latency)→10→00 while `mem_stall` is low.
  - It samples `mem_addr` on the cycle it reads, so `mem_addr` stays stable whenever no redirect is pending.
  - `mem_stall` high forces memory to 00 next edge and discards progress.
- `mem_stall = rst | redirect_valid | (count == DEPTH)`. Conservative: stays high when full even if a pop occurs that cycle.
- Push: when `mem_status == 10` and no redirect, enqueue `{pc, mem_rdata}` and set `pc <= pc + 4` (mod 2^32 wrap).
- A 10 beat with `count == DEPTH` is impossible by construction; flag it with an assertion and drop the word.
- Pop: when `out_valid & out_ready`, the head advances. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority):
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The queue is flushed (`count <= 0`).
  - Any same-cycle 10 beat is discarded and the PC is not incremented.
  - `out_valid` is combinationally masked to 0 in that cycle, so no handshake occurs.
- Back-to-back redirects: the last one wins. Each redirect cycle keeps memory stalled.
- Outputs are driven from the queue head. `out_pc`/`out_inst` are don't-care when `out_valid` is 0 but must be held stable while `out_valid & !out_ready`.

## Timing
- Reset values: `pc = RESET_PC`, `count = 0`, `out_valid = 0`, `mem_stall = 1`, `mem_addr = RESET_PC`, `out_pc`/`out_inst = 0`.
- Latency is given for a memory with `latency_cycles = 1`, where e1 is the first edge with `rst` sampled low:
  - e1: memory 00→01.
  - e3: memory reads and goes to 10.
  - e4: push; `out_valid` rises after e4 with `out_pc = RESET_PC`.
- Steady throughput: one instruction per 4 cycles (00, 01, 01, 10) when decode always accepts.
- A redirect at edge r: memory restarts from 00 after r. The first target instruction reaches `out_valid` 4 edges after the first non-redirect edge.
- Full stall: memory is held at 00. It resumes the 00→01 sequence on the edge after `count` drops below DEPTH.
- Reset mid-operation: pc, queue and outputs return to reset values on the next edge, regardless of `mem_status` or handshake.

## Structure
- `fetch_pkg`:
  - `mem_status_e` (`MS_IDLE = 2'b00`, `MS_PEND = 2'b01`, `MS_VALID = 2'b10`).
  - `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] inst;}`.
  - `INST_BYTES = 4`.
- Sub-module `fetch_queue`:
  - Parameterised FIFO of `fetch_entry_t`, with push/pop/flush, `count`, `full`/`empty`.
  - Flush beats push.
- `inst_fetch` holds the PC, the stall logic and the redirect masking.

## Test plan
- Reset release, memory model latency 1, `out_ready = 1`:
  - Entries `0xBFC00000`, `0xBFC00004`, `0xBFC00008` arrive with matching `mem_rdata`.
  - `out_valid` first high after e4, then one beat every 4 cycles.
- `out_ready = 0` for 20 cycles:
  - `count` reaches 2 and `mem_stall` stays high; memory status holds at 00.
  - After `out_ready = 1`, PCs continue `+4` with no gap or duplicate.
- Redirect to `0x80000103` while memory is at 01:
  - Next fetched `out_pc = 0x80000100`.
  - The old in-flight word is never output.
  - `out_valid = 0` during the redirect cycle.
- Redirect coincident with a `mem_status = 10` beat and a full queue:
  - The beat is dropped and the queue empties.
  - PC equals the target, not target+4.
- `RESET_PC = 32'hFFFF_FFFC`:
  - Second fetch address wraps to `0x00000000`.
- `rst` asserted while memory is at 10 and `out_valid = 1`:
  - All outputs return to reset values on the next edge.
